// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters plus a condition-code
// writer counter for the decode stage. Decode gets a combinational issue/stall
// answer that already accounts for a writeback retiring in the same cycle;
// the issue itself is recorded on the clock edge.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 2,
  parameter int CC_CNT_W = 3
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET,
  input  logic                I_IssueValid,
  input  logic                I_Src1Used,
  input  logic [IDX_W-1:0]    I_Src1Idx,
  input  logic                I_Src2Used,
  input  logic [IDX_W-1:0]    I_Src2Idx,
  input  logic                I_DestUsed,
  input  logic [IDX_W-1:0]    I_DestIdx,
  input  logic                I_ReadsCC,
  input  logic                I_WritesCC,
  input  logic                I_WbEnable,
  input  logic [IDX_W-1:0]    I_WbRegIdx,
  input  logic                I_WbSetsCC,
  output logic                O_Stall,
  output logic                O_IssueAck,
  output logic [NUM_REGS-1:0] O_PendingMask,
  output logic                O_CCPending,
  output logic                O_Underflow
);

  // Lookup tables span the full index space so any index can be used
  // directly; entries at or above NUM_REGS read as never pending.
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;
  localparam logic [CC_CNT_W-1:0] CC_CNT_MAX = '1;

  logic [CNT_W-1:0]    r_count [NUM_REGS];
  logic [CC_CNT_W-1:0] r_cc_count;
  logic [NUM_REGS-1:0] r_pending_mask;
  logic                r_cc_pending;
  logic                r_underflow;

  logic [CNT_W-1:0]    w_eff       [DEPTH];
  logic [DEPTH-1:0]    w_dec;
  logic [CNT_W-1:0]    w_count_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_mask_nxt;
  logic                w_cc_dec;
  logic [CC_CNT_W-1:0] w_eff_cc;
  logic [CC_CNT_W-1:0] w_cc_nxt;
  logic                w_stall;
  logic                w_ack;
  logic                w_underflow_evt;

  // Counter step: simultaneous inc and dec cancel; stall logic guarantees
  // inc never lands on a saturated counter and dec is only raised when nonzero.
  function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    if (inc && !dec)      step_cnt = cnt + CNT_W'(1);
    else if (dec && !inc) step_cnt = cnt - CNT_W'(1);
    else                  step_cnt = cnt;
  endfunction

  function automatic logic [CC_CNT_W-1:0] step_cc(input logic [CC_CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    if (inc && !dec)      step_cc = cnt + CC_CNT_W'(1);
    else if (dec && !inc) step_cc = cnt - CC_CNT_W'(1);
    else                  step_cc = cnt;
  endfunction

  // Effective counts with the same-cycle writeback already retired (bypass).
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_eff[i] = '0;
      if (i < NUM_REGS) begin
        w_dec[i] = I_WbEnable && (I_WbRegIdx == IDX_W'(i)) && (r_count[i] != '0);
        w_eff[i] = r_count[i] - CNT_W'(w_dec[i]);
      end
    end
    w_cc_dec = I_WbEnable && I_WbSetsCC && (r_cc_count != '0);
    w_eff_cc = r_cc_count - CC_CNT_W'(w_cc_dec);
  end

  // Issue decision: hazards on sources/CC, or no room left in a counter.
  always_comb begin
    w_stall = 1'b0;
    if (I_IssueValid) begin
      w_stall = (I_Src1Used && (w_eff[I_Src1Idx] != '0))
             || (I_Src2Used && (w_eff[I_Src2Idx] != '0))
             || (I_ReadsCC  && (w_eff_cc != '0))
             || (I_DestUsed && (w_eff[I_DestIdx] == CNT_MAX))
             || (I_WritesCC && (w_eff_cc == CC_CNT_MAX));
    end
    w_ack = I_IssueValid && !w_stall;
  end

  // Next-state counters, mask, and underflow event detection.
  always_comb begin
    w_mask_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_count_nxt[i] = step_cnt(r_count[i],
                                w_ack && I_DestUsed && (I_DestIdx == IDX_W'(i)),
                                w_dec[i]);
      w_mask_nxt[i]  = (w_count_nxt[i] != '0);
    end
    w_cc_nxt = step_cc(r_cc_count, w_ack && I_WritesCC, w_cc_dec);
    // A register writeback that decremented nothing found a zero (or untracked) count.
    w_underflow_evt = (I_WbEnable && (w_dec == '0))
                   || (I_WbEnable && I_WbSetsCC && !w_cc_dec);
  end

  // State update; reset discards all in-flight tracking.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_count[i] <= '0;
      r_cc_count     <= '0;
      r_pending_mask <= '0;
      r_cc_pending   <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_count[i] <= w_count_nxt[i];
      r_cc_count     <= w_cc_nxt;
      r_pending_mask <= w_mask_nxt;
      r_cc_pending   <= (w_cc_nxt != '0);
      r_underflow    <= r_underflow || w_underflow_evt;
    end
  end

  assign O_Stall       = w_stall;
  assign O_IssueAck    = w_ack;
  assign O_PendingMask = r_pending_mask;
  assign O_CCPending   = r_cc_pending;
  assign O_Underflow   = r_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        src1_used;
  logic [3:0]  src1_idx;
  logic        src2_used;
  logic [3:0]  src2_idx;
  logic        dest_used;
  logic [3:0]  dest_idx;
  logic        reads_cc;
  logic        writes_cc;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic        wb_sets_cc;
  logic        stall;
  logic        ack;
  logic [15:0] pmask;
  logic        cc_pend;
  logic        uflow;

  int n_chk  = 0;
  int n_pass = 0;

  reg_scoreboard #(.NUM_REGS(16), .IDX_W(4), .CNT_W(2), .CC_CNT_W(3)) dut (
    .I_CLOCK       (clk),
    .I_RESET       (rst),
    .I_IssueValid  (issue_valid),
    .I_Src1Used    (src1_used),
    .I_Src1Idx     (src1_idx),
    .I_Src2Used    (src2_used),
    .I_Src2Idx     (src2_idx),
    .I_DestUsed    (dest_used),
    .I_DestIdx     (dest_idx),
    .I_ReadsCC     (reads_cc),
    .I_WritesCC    (writes_cc),
    .I_WbEnable    (wb_en),
    .I_WbRegIdx    (wb_idx),
    .I_WbSetsCC    (wb_sets_cc),
    .O_Stall       (stall),
    .O_IssueAck    (ack),
    .O_PendingMask (pmask),
    .O_CCPending   (cc_pend),
    .O_Underflow   (uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; src1_used = 0; src1_idx = 0; src2_used = 0; src2_idx = 0;
    dest_used = 0; dest_idx = 0; reads_cc = 0; writes_cc = 0;
    wb_en = 0; wb_idx = 0; wb_sets_cc = 0;
  endtask

  task automatic issue(input logic s1u, input logic [3:0] s1, input logic s2u, input logic [3:0] s2,
                       input logic du, input logic [3:0] d, input logic rcc, input logic wcc);
    issue_valid = 1; src1_used = s1u; src1_idx = s1; src2_used = s2u; src2_idx = s2;
    dest_used = du; dest_idx = d; reads_cc = rcc; writes_cc = wcc;
  endtask

  task automatic wb(input logic [3:0] idx, input logic cc);
    wb_en = 1; wb_idx = idx; wb_sets_cc = cc;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    check("rst_mask", 32'(pmask), 32'h0);
    check("rst_ccpend", 32'(cc_pend), 32'h0);
    check("rst_uflow", 32'(uflow), 32'h0);

    // 1: issue Dest=R3, then Src1=R3 stalls, WB R3 clears
    issue(0, 0, 0, 0, 1, 3, 0, 0); #1;
    check("t1_issue_ack", 32'(ack), 32'h1);
    tick(); idle(); #1;
    check("t1_mask3", 32'(pmask), 32'h0008);
    issue(1, 3, 0, 0, 0, 0, 0, 0); #1;
    check("t1_src_stall", 32'(stall), 32'h1);
    check("t1_src_noack", 32'(ack), 32'h0);
    issue_valid = 0; #1;
    check("t1_novalid_nostall", 32'(stall), 32'h0);
    idle(); wb(3, 0);
    tick(); idle(); #1;
    check("t1_mask_clear", 32'(pmask), 32'h0);

    // 2: two issues to R5, two writebacks
    issue(0, 0, 0, 0, 1, 5, 0, 0); #1;
    check("t2_ack_a", 32'(ack), 32'h1);
    tick(); #1;
    check("t2_ack_b", 32'(ack), 32'h1);
    tick(); idle(); wb(5, 0);
    tick(); idle(); #1;
    check("t2_mask_after_1wb", 32'(pmask), 32'h0020);
    issue(0, 0, 1, 5, 0, 0, 0, 0); #1;
    check("t2_src2_stall", 32'(stall), 32'h1);
    idle(); wb(5, 0);
    tick(); idle(); #1;
    check("t2_mask_clear", 32'(pmask), 32'h0);

    // 3: bypass of same-cycle writeback
    issue(0, 0, 0, 0, 1, 2, 0, 0);
    tick(); idle();
    issue(1, 2, 0, 0, 0, 0, 0, 0); wb(2, 0); #1;
    check("t3_bypass_stall", 32'(stall), 32'h0);
    check("t3_bypass_ack", 32'(ack), 32'h1);
    tick(); idle(); #1;
    check("t3_mask_clear", 32'(pmask), 32'h0);

    // 4: counter saturation on R4
    issue(0, 0, 0, 0, 1, 4, 0, 0);
    tick(); tick(); #1;
    check("t4_third_ack", 32'(ack), 32'h1);
    tick(); #1;
    check("t4_sat_stall", 32'(stall), 32'h1);
    wb(4, 0); #1;
    check("t4_sat_wb_ack", 32'(ack), 32'h1);
    tick(); wb_en = 0; #1;
    check("t4_still_sat", 32'(stall), 32'h1);
    check("t4_mask", 32'(pmask), 32'h0010);
    idle(); wb(4, 0);
    tick(); tick(); idle(); #1;
    check("t4_mask_after_2wb", 32'(pmask), 32'h0010);
    wb(4, 0);
    tick(); idle(); #1;
    check("t4_mask_drained", 32'(pmask), 32'h0);
    check("t4_no_uflow", 32'(uflow), 32'h0);

    // 5: CC producer then branch consumer
    issue(0, 0, 0, 0, 1, 1, 0, 1);
    tick(); idle(); #1;
    check("t5_ccpend", 32'(cc_pend), 32'h1);
    issue(0, 0, 0, 0, 0, 0, 1, 0); #1;
    check("t5_br_stall", 32'(stall), 32'h1);
    tick(); #1;
    check("t5_br_stall_again", 32'(stall), 32'h1);
    wb(1, 1); #1;
    check("t5_br_bypass_ack", 32'(ack), 32'h1);
    tick(); idle(); #1;
    check("t5_cc_clear", 32'(cc_pend), 32'h0);
    check("t5_mask_clear", 32'(pmask), 32'h0);
    check("t5_no_uflow", 32'(uflow), 32'h0);

    // 6: underflow, sticky, then reset with pending issue
    wb(7, 0);
    tick(); idle(); #1;
    check("t6_uflow_set", 32'(uflow), 32'h1);
    tick(); #1;
    check("t6_uflow_sticky", 32'(uflow), 32'h1);
    issue(0, 0, 0, 0, 1, 9, 0, 1); rst = 1;
    tick(); idle(); rst = 0; #1;
    check("t6_rst_mask", 32'(pmask), 32'h0);
    check("t6_rst_ccpend", 32'(cc_pend), 32'h0);
    check("t6_rst_uflow", 32'(uflow), 32'h0);
    wb(9, 0);
    tick(); idle(); #1;
    check("t6_discarded_uflow", 32'(uflow), 32'h1);

    // CC underflow alone: register write is legitimate, CC count is zero
    rst = 1; tick(); rst = 0;
    issue(0, 0, 0, 0, 1, 6, 0, 0);
    tick(); idle(); #1;
    check("t7_mask6", 32'(pmask), 32'h0040);
    wb(6, 1);
    tick(); idle(); #1;
    check("t7_cc_uflow", 32'(uflow), 32'h1);
    check("t7_mask_clear", 32'(pmask), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
